// File: rtl/pr_free_list_if.sv
// Free-list port bundle: ROB-side enqueue, rename-side per-bank dequeue and status.
// master = ROB/rename side, slave = pr_free_list.
interface pr_free_list_if #(
   parameter int unsigned LOG_PR_COUNT         = 7,
   parameter int unsigned FREE_LIST_BANK_COUNT = 4,
   parameter int unsigned BANK_COUNT_WIDTH     = 6
);
   logic                                                enq_valid;
   logic [LOG_PR_COUNT-1:0]                             enq_PR;
   logic [FREE_LIST_BANK_COUNT-1:0]                     deq_req_valid_by_bank;
   logic [FREE_LIST_BANK_COUNT-1:0]                     deq_req_ready_by_bank;
   logic [FREE_LIST_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   deq_PR_by_bank;
   logic [FREE_LIST_BANK_COUNT-1:0][BANK_COUNT_WIDTH-1:0] bank_count_by_bank;
   logic [FREE_LIST_BANK_COUNT-1:0]                     low_by_bank;
   logic                                                overflow_error;

   modport master (
      output enq_valid,
      output enq_PR,
      output deq_req_valid_by_bank,
      input  deq_req_ready_by_bank,
      input  deq_PR_by_bank,
      input  bank_count_by_bank,
      input  low_by_bank,
      input  overflow_error
   );

   modport slave (
      input  enq_valid,
      input  enq_PR,
      input  deq_req_valid_by_bank,
      output deq_req_ready_by_bank,
      output deq_PR_by_bank,
      output bank_count_by_bank,
      output low_by_bank,
      output overflow_error
   );
endinterface

// File: rtl/pr_free_list.sv
// Banked physical-register free list: one circular FIFO of PR numbers per bank (bank = PR[1:0]).
// Optional macro PR_FREE_LIST_BYPASS_EN forwards an enqueue straight to an empty bank's dequeue.
module pr_free_list #(
   parameter int unsigned PR_COUNT                  = 128,
   parameter int unsigned LOG_PR_COUNT              = 7,
   parameter int unsigned AR_COUNT                  = 32,
   parameter int unsigned FREE_LIST_BANK_COUNT      = 4,
   parameter int unsigned FREE_LIST_LENGTH_PER_BANK = 32,
   parameter int unsigned FREE_LIST_LOWER_THRESHOLD = 8
) (
   input logic          CLK,
   input logic          RST,
   pr_free_list_if.slave fl
);

   localparam int unsigned BANK_W        = $clog2(FREE_LIST_BANK_COUNT);
   localparam int unsigned PTR_W         = $clog2(FREE_LIST_LENGTH_PER_BANK);
   localparam int unsigned CNT_W         = PTR_W + 1;
   localparam int unsigned INIT_PER_BANK = (PR_COUNT - AR_COUNT) / FREE_LIST_BANK_COUNT;

   logic [LOG_PR_COUNT-1:0] mem_q   [FREE_LIST_BANK_COUNT][FREE_LIST_LENGTH_PER_BANK];
   logic [PTR_W-1:0]        head_q  [FREE_LIST_BANK_COUNT];
   logic [PTR_W-1:0]        tail_q  [FREE_LIST_BANK_COUNT];
   logic [CNT_W-1:0]        count_q [FREE_LIST_BANK_COUNT];
   logic [CNT_W-1:0]        count_d [FREE_LIST_BANK_COUNT];
   logic                    overflow_q;

   logic [BANK_W-1:0]                                  enq_bank;
   logic [FREE_LIST_BANK_COUNT-1:0]                    enq_sel;
   logic [FREE_LIST_BANK_COUNT-1:0]                    enq_hit;
   logic [FREE_LIST_BANK_COUNT-1:0]                    deq_fire;
   logic [FREE_LIST_BANK_COUNT-1:0]                    ready;
   logic [FREE_LIST_BANK_COUNT-1:0]                    empty;
   logic [FREE_LIST_BANK_COUNT-1:0]                    full;
   logic [FREE_LIST_BANK_COUNT-1:0]                    low;
   logic [FREE_LIST_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  deq_pr;
   logic [FREE_LIST_BANK_COUNT-1:0][CNT_W-1:0]         count_out;
   logic                                               overflow_hit;

   assign enq_bank = fl.enq_PR[BANK_W-1:0];

   always_comb begin
      overflow_hit = 1'b0;
      for (int b = 0; b < int'(FREE_LIST_BANK_COUNT); b++) begin
         empty[b]   = (count_q[b] == '0);
         full[b]    = (count_q[b] == CNT_W'(FREE_LIST_LENGTH_PER_BANK));
         enq_sel[b] = fl.enq_valid && (enq_bank == BANK_W'(b));
`ifdef PR_FREE_LIST_BYPASS_EN
         // An empty bank offers the incoming PR directly; storage write is then don't-care.
         ready[b]  = !empty[b] || enq_sel[b];
         deq_pr[b] = empty[b] ? fl.enq_PR : mem_q[b][head_q[b]];
`else
         ready[b]  = !empty[b];
         deq_pr[b] = mem_q[b][head_q[b]];
`endif
         deq_fire[b] = fl.deq_req_valid_by_bank[b] && ready[b];
         // A full bank still accepts a write when its head slot frees up this cycle.
         enq_hit[b]  = enq_sel[b] && (!full[b] || deq_fire[b]);
         if (enq_sel[b] && full[b] && !deq_fire[b]) begin
            overflow_hit = 1'b1;
         end
         count_d[b]   = count_q[b] + CNT_W'(enq_hit[b]) - CNT_W'(deq_fire[b]);
         low[b]       = (count_q[b] < CNT_W'(FREE_LIST_LOWER_THRESHOLD));
         count_out[b] = count_q[b];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         overflow_q <= 1'b0;
         for (int b = 0; b < int'(FREE_LIST_BANK_COUNT); b++) begin
            head_q[b]  <= '0;
            tail_q[b]  <= PTR_W'(INIT_PER_BANK);
            count_q[b] <= CNT_W'(INIT_PER_BANK);
            for (int i = 0; i < int'(INIT_PER_BANK); i++) begin
               mem_q[b][i] <= LOG_PR_COUNT'(AR_COUNT + FREE_LIST_BANK_COUNT * i + b);
            end
         end
      end else begin
         if (overflow_hit) begin
            overflow_q <= 1'b1;
         end
         for (int b = 0; b < int'(FREE_LIST_BANK_COUNT); b++) begin
            if (enq_hit[b]) begin
               mem_q[b][tail_q[b]] <= fl.enq_PR;
               tail_q[b]           <= tail_q[b] + PTR_W'(1);
            end
            if (deq_fire[b]) begin
               head_q[b] <= head_q[b] + PTR_W'(1);
            end
            count_q[b] <= count_d[b];
         end
      end
   end

   assign fl.deq_req_ready_by_bank = ready;
   assign fl.deq_PR_by_bank        = deq_pr;
   assign fl.bank_count_by_bank    = count_out;
   assign fl.low_by_bank           = low;
   assign fl.overflow_error        = overflow_q;

   for (genvar g = 0; g < int'(FREE_LIST_BANK_COUNT); g++) begin : g_chk
      // Pointer distance must always equal occupancy (modulo depth).
      assert property (@(posedge CLK) disable iff (RST)
         count_q[g] <= CNT_W'(FREE_LIST_LENGTH_PER_BANK));
      assert property (@(posedge CLK) disable iff (RST)
         (tail_q[g] - head_q[g]) == count_q[g][PTR_W-1:0]);
   end

endmodule
